elbeth_dmem_responder: RTL and testbench



---
 rtl/elbeth_dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_elbeth_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_dmem_responder.sv
// Single-port data-memory responder for the Elbeth core: accepts one request at a time,
// inserts a fixed number of wait states, then returns one response strobe.
`timescale 1ns/1ps

module elbeth_dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_en,
    input  logic [3:0]  dmem_wr,
    input  logic [31:0] dmem_out_data,
    output logic [31:0] dmem_in_data,
    output logic        dmem_ready,
    output logic        dmem_error,
    output logic [7:0]  dbg_err_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         errcnt_q, errcnt_d;

    logic [32:0]            off;
    logic [ADDR_WIDTH-1:0]  idx;
    logic                   oor;
    logic                   bad_strobe;
    logic                   misalign;
    logic                   req_err;
    logic                   enter_resp;
    logic                   mem_we;
    logic [31:0]            cur_word;
    logic [31:0]            merged_word;

    logic [31:0] mem_q [DEPTH];

    // Next-state logic and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (dmem_en) begin
                    addr_d  = dmem_addr;
                    wr_d    = dmem_wr;
                    wdata_d = dmem_out_data;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES != 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request decode on the pending request (the captured one, or the one being accepted)
    always_comb begin
        off        = {1'b0, addr_d} - {1'b0, BASE_ADDR};
        oor        = off[32] || (off >= SPAN);
        idx        = off[ADDR_WIDTH+1:2];
        bad_strobe = 1'b0;
        misalign   = 1'b0;
        case (wr_d)
            4'b0000: misalign = 1'b0;
            4'b0001,
            4'b0011,
            4'b1111: misalign = (addr_d[1:0] != 2'd0);
            4'b0010: misalign = (addr_d[1:0] != 2'd1);
            4'b0100,
            4'b1100: misalign = (addr_d[1:0] != 2'd2);
            4'b1000: misalign = (addr_d[1:0] != 2'd3);
            default: bad_strobe = 1'b1;
        endcase
        req_err = oor || bad_strobe || misalign;
    end

    assign cur_word = mem_q[idx];

    // Lane merge for a strobed write into the addressed word
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_q[b]) begin
                merged_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Response outputs are computed on the edge that enters RESP
    always_comb begin
        enter_resp = (state_d == RESP);
        ready_d    = enter_resp;
        error_d    = enter_resp && req_err;
        rdata_d    = 32'h0;
        errcnt_d   = errcnt_q;
        if (enter_resp && !req_err && (wr_d == 4'b0000)) begin
            rdata_d = cur_word;
        end
        if (enter_resp && req_err && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // A reset landing on the RESP edge abandons the write
    assign mem_we = (state_q == RESP) && !error_q && (wr_q != 4'b0000) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Backing array is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= merged_word;
        end
    end

    assign dmem_in_data  = rdata_q;
    assign dmem_ready    = ready_q;
    assign dmem_error    = error_q;
    assign dbg_err_count = errcnt_q;

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// Bench for elbeth_dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
`timescale 1ns/1ps

module tb_elbeth_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] addr_s [3];
    logic        en_s   [3];
    logic [3:0]  wr_s   [3];
    logic [31:0] wd_s   [3];
    logic [31:0] rd_s   [3];
    logic        rdy_s  [3];
    logic        err_s  [3];
    logic [7:0]  cnt_s  [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;
    int wcs [3]   = '{1, 0, 3};

    elbeth_dmem_responder #(.WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .dmem_addr(addr_s[0]), .dmem_en(en_s[0]), .dmem_wr(wr_s[0]),
        .dmem_out_data(wd_s[0]), .dmem_in_data(rd_s[0]), .dmem_ready(rdy_s[0]),
        .dmem_error(err_s[0]), .dbg_err_count(cnt_s[0]));
    elbeth_dmem_responder #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .dmem_addr(addr_s[1]), .dmem_en(en_s[1]), .dmem_wr(wr_s[1]),
        .dmem_out_data(wd_s[1]), .dmem_in_data(rd_s[1]), .dmem_ready(rdy_s[1]),
        .dmem_error(err_s[1]), .dbg_err_count(cnt_s[1]));
    elbeth_dmem_responder #(.WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .dmem_addr(addr_s[2]), .dmem_en(en_s[2]), .dmem_wr(wr_s[2]),
        .dmem_out_data(wd_s[2]), .dmem_in_data(rd_s[2]), .dmem_ready(rdy_s[2]),
        .dmem_error(err_s[2]), .dbg_err_count(cnt_s[2]));

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // Error rule from the request's address and strobes (BASE_ADDR 0, 1024 words)
    function automatic logic m_err(input logic [31:0] a, input logic [3:0] w);
        int low;
        if (a >= 32'd4096) return 1'b1;
        if (!(w inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
            return 1'b1;
        if (w == 4'b0000) return 1'b0;
        low = 0;
        while (low < 3 && !w[low]) low++;
        return a[1:0] != 2'(low);
    endfunction

    // Transaction model: one outstanding request per instance, response due WAIT_CYCLES after accept
    logic [31:0] mem_m [int];
    bit          busy   [3];
    int          due    [3];
    logic [31:0] ra     [3];
    logic [3:0]  rw     [3];
    logic [31:0] rdm    [3];
    logic        exp_rdy[3];
    logic        exp_err[3];
    logic [31:0] exp_dat[3];
    int          exp_cnt[3];
    int          cyc = 0;

    always @(posedge clk) begin : model
        logic [31:0] w0;
        int key;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            key = k * 4096 + int'(ra[k] >> 2);
            if (rst) begin
                busy[k]    = 1'b0;
                exp_cnt[k] = 0;
            end else if (!busy[k] && en_s[k]) begin
                ra[k]   = addr_s[k];
                rw[k]   = wr_s[k];
                rdm[k]  = wd_s[k];
                busy[k] = 1'b1;
                due[k]  = cyc + wcs[k];
            end else if (busy[k] && cyc == due[k] + 1) begin
                if (!m_err(ra[k], rw[k]) && rw[k] != 4'b0000) begin
                    w0 = mem_m.exists(key) ? mem_m[key] : 32'hx;
                    for (int b = 0; b < 4; b++)
                        if (rw[k][b]) w0[8*b +: 8] = rdm[k][8*b +: 8];
                    mem_m[key] = w0;
                end
                busy[k] = 1'b0;
            end
            key        = k * 4096 + int'(ra[k] >> 2);
            exp_rdy[k] = busy[k] && (cyc == due[k]);
            exp_err[k] = 1'b0;
            exp_dat[k] = 32'h0;
            if (exp_rdy[k]) begin
                exp_err[k] = m_err(ra[k], rw[k]);
                if (exp_err[k]) begin
                    if (exp_cnt[k] < 255) exp_cnt[k]++;
                end else if (rw[k] == 4'b0000) begin
                    exp_dat[k] = mem_m.exists(key) ? mem_m[key] : 32'hx;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d.ready", k), 32'(rdy_s[k]), 32'(exp_rdy[k]));
                chk($sformatf("u%0d.error", k), 32'(err_s[k]), 32'(exp_err[k]));
                chk($sformatf("u%0d.errcnt", k), 32'(cnt_s[k]), 32'(exp_cnt[k]));
                if (!$isunknown(exp_dat[k]))
                    chk($sformatf("u%0d.in_data", k), rd_s[k], exp_dat[k]);
            end
        end
    end

    // One request; returns response data/error and latency in cycles after the accept edge (0 = timeout)
    task automatic req(input int k, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       output logic [31:0] rdat, output logic rerr, output int lat);
        lat  = 0;
        rdat = 32'hx;
        rerr = 1'bx;
        en_s[k] = 1'b1; addr_s[k] = a; wr_s[k] = w; wd_s[k] = d;
        @(posedge clk); #1;
        en_s[k] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy_s[k]) begin
                rdat = rd_s[k]; rerr = err_s[k]; lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_wr(input int k, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                         input logic e, input string nm);
        logic [31:0] rdat; logic rerr; int lat;
        req(k, a, w, d, rdat, rerr, lat);
        chk({nm, ".lat"}, 32'(lat), 32'(1 + wcs[k]));
        chk({nm, ".err"}, 32'(rerr), 32'(e));
        chk({nm, ".data"}, rdat, 32'h0);
    endtask

    task automatic do_rd(input int k, input logic [31:0] a, input logic [31:0] x, input logic e,
                         input string nm);
        logic [31:0] rdat; logic rerr; int lat;
        req(k, a, 4'b0000, 32'h0, rdat, rerr, lat);
        chk({nm, ".lat"}, 32'(lat), 32'(1 + wcs[k]));
        chk({nm, ".err"}, 32'(rerr), 32'(e));
        chk({nm, ".data"}, rdat, x);
    endtask

    // Hold dmem_en for n cycles and record response pulse positions
    task automatic held(input int k, input logic [31:0] a, input int n,
                        output int pulses, output int first, output int gap);
        int prev;
        pulses = 0; first = -1; gap = -1; prev = -1;
        en_s[k] = 1'b1; addr_s[k] = a; wr_s[k] = 4'b0000; wd_s[k] = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rdy_s[k]) begin
                if (pulses == 0) first = i;
                else if (pulses == 1) gap = i - prev;
                prev = i;
                pulses++;
            end
            @(posedge clk); #1;
        end
        en_s[k] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses, first, gap;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en_s[k] = 1'b0; addr_s[k] = 32'h0; wr_s[k] = 4'h0; wd_s[k] = 32'h0;
        end
        @(posedge clk); #1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.ready", 32'(rdy_s[0]), 32'h0);
        chk("reset.in_data", rd_s[0], 32'h0);
        chk("reset.errcnt", 32'(cnt_s[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word write/read, byte merge, error cases
        do_wr(0, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0, "wr10");
        do_rd(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "rd10");
        do_wr(0, 32'h11, 4'b0010, 32'h0000_1200, 1'b0, "wrbyte1");
        do_rd(0, 32'h10, 32'hDEAD_12EF, 1'b0, "rdmerge");
        do_wr(0, 32'h12, 4'b1111, 32'h1111_1111, 1'b1, "misalign");
        chk("misalign.cnt", 32'(cnt_s[0]), 32'd1);
        do_rd(0, 32'h10, 32'hDEAD_12EF, 1'b0, "rdunchanged");
        do_wr(0, 32'h10, 4'b0101, 32'h2222_2222, 1'b1, "badstrobe");
        chk("badstrobe.cnt", 32'(cnt_s[0]), 32'd2);
        do_rd(0, 32'h1000, 32'h0, 1'b1, "oor");
        chk("oor.cnt", 32'(cnt_s[0]), 32'd3);
        do_wr(0, 32'h13, 4'b1000, 32'hAB00_0000, 1'b0, "wrbyte3");
        do_rd(0, 32'h13, 32'hABAD_12EF, 1'b0, "rdbyte3");
        do_wr(0, 32'hFFC, 4'b1111, 32'h0BAD_F00D, 1'b0, "wrlast");
        do_rd(0, 32'hFFC, 32'h0BAD_F00D, 1'b0, "rdlast");

        // Reset during WAIT abandons the write
        do_wr(0, 32'h20, 4'b1111, 32'hCAFE_0020, 1'b0, "wr20");
        en_s[0] = 1'b1; addr_s[0] = 32'h20; wr_s[0] = 4'b1111; wd_s[0] = 32'h5555_5555;
        @(posedge clk); #1;
        en_s[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midop.wait_ready", 32'(rdy_s[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midop.ready", 32'(rdy_s[0]), 32'h0);
        chk("midop.in_data", rd_s[0], 32'h0);
        chk("midop.errcnt", 32'(cnt_s[0]), 32'h0);
        @(posedge clk); #1;
        do_rd(0, 32'h20, 32'hCAFE_0020, 1'b0, "rd20");

        // Request presented on the reset cycle is dropped
        en_s[0] = 1'b1; addr_s[0] = 32'h20; wr_s[0] = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        en_s[0] = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy_s[0]) pulses++;
            @(posedge clk); #1;
        end
        chk("rsten.pulses", 32'(pulses), 32'h0);

        // Latency sweep on the zero- and three-wait instances
        do_wr(1, 32'h40, 4'b1111, 32'h0123_4567, 1'b0, "w0.wr");
        do_rd(1, 32'h40, 32'h0123_4567, 1'b0, "w0.rd");
        do_wr(2, 32'h44, 4'b1111, 32'h89AB_CDEF, 1'b0, "w3.wr");
        do_rd(2, 32'h44, 32'h89AB_CDEF, 1'b0, "w3.rd");
        do_wr(2, 32'h46, 4'b1100, 32'h7777_0000, 1'b0, "w3.half");
        do_rd(2, 32'h44, 32'h7777_CDEF, 1'b0, "w3.rdhalf");

        held(2, 32'h44, 60, pulses, first, gap);
        chk("held3.first", 32'(first), 32'd4);
        chk("held3.gap", 32'(gap), 32'd5);
        chk("held3.pulses", 32'(pulses), 32'd12);

        // Error counter saturation
        held(1, 32'h2000, 540, pulses, first, gap);
        chk("sat.first", 32'(first), 32'd1);
        chk("sat.gap", 32'(gap), 32'd2);
        chk("sat.pulses", 32'(pulses), 32'd270);
        chk("sat.cnt", 32'(cnt_s[1]), 32'hFF);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
